// File: rtl/project_switch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : project_switch_ctrl
// Description : Wishbone-programmable selector for the active user project.
//               It owns one config register and sequences every switch:
//               drain the bus, isolate the IOs, hold all projects in reset,
//               change the select, then release the new project.
//               Optional sticky lock: define PROJECT_SWITCH_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module project_switch_ctrl #(
    parameter int          USER_PROJECTS = 4,
    parameter int          SEL_BITS      = $clog2(USER_PROJECTS),
    parameter logic [31:0] CFG_ADDRESS   = 32'h300F_FFFC,
    parameter int          GUARD_CYCLES  = 8,
    parameter int          RST_CYCLES    = 4,
    parameter int          DRAIN_TIMEOUT = 256
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_dat_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     cfg_hit_o,
    output logic                     cfg_ack_o,
    output logic [31:0]              cfg_dat_o,
    output logic [SEL_BITS-1:0]      active_sel_o,
    output logic [USER_PROJECTS-1:0] proj_rst_o,
    output logic                     io_isolate_o,
    output logic                     switch_busy_o,
    output logic                     switch_irq_o
);

    // One shared counter times DRAIN, ISOLATE and RESET; size it for the longest.
    localparam int c_MAX_GR  = (GUARD_CYCLES > RST_CYCLES) ? GUARD_CYCLES : RST_CYCLES;
    localparam int c_CNT_MAX = (DRAIN_TIMEOUT > c_MAX_GR) ? DRAIN_TIMEOUT : c_MAX_GR;
    localparam int c_CW      = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CW-1:0]          c_DRAIN_LAST = c_CW'(DRAIN_TIMEOUT - 1);
    localparam logic [c_CW-1:0]          c_GUARD_LAST = c_CW'(GUARD_CYCLES - 1);
    localparam logic [c_CW-1:0]          c_RST_LAST   = c_CW'(RST_CYCLES - 1);
    localparam logic [7:0]               c_NPROJ      = 8'(USER_PROJECTS);
    localparam logic [USER_PROJECTS-1:0] c_ONE        = {{(USER_PROJECTS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_ISOLATE = 3'd2,
        S_RESET   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CW-1:0]     r_cnt;
    logic                r_ack;
    logic [SEL_BITS-1:0] r_active_sel;
    logic [SEL_BITS-1:0] r_target;
    logic [SEL_BITS-1:0] r_pend_target;
    logic                r_pending;
    logic                r_err;

    logic                w_acc;
    logic                w_wr_cycle;
    logic                w_sel_req;
    logic [7:0]          w_wdat8;
    logic [SEL_BITS-1:0] w_wdat;
    logic                w_in_range;
    logic                w_sel_ok;
    logic                w_sel_bad;
    logic                w_lock;
    logic                w_lock_set;
    logic                w_start;
    logic [SEL_BITS-1:0] w_start_tgt;
    logic                w_unused;

    // Config decode does not depend on the switch state.
    assign cfg_hit_o  = (wbs_adr_i == CFG_ADDRESS);
    assign w_acc      = wbs_stb_i & wbs_cyc_i & cfg_hit_o;
    // Writes commit at the end of the ack cycle while the master still holds the request.
    assign w_wr_cycle = r_ack & w_acc & wbs_we_i;
    assign w_sel_req  = w_wr_cycle & wbs_sel_i[0];
    // The select field is the whole low byte so out-of-range values are visible.
    assign w_wdat8    = wbs_dat_i[7:0];
    assign w_wdat     = w_wdat8[SEL_BITS-1:0];
    assign w_in_range = (w_wdat8 < c_NPROJ);
    assign w_sel_ok   = w_sel_req & w_in_range & ~w_lock;
    assign w_sel_bad  = w_sel_req & ~(w_in_range & ~w_lock);
    assign w_unused   = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

    assign cfg_ack_o    = r_ack;
    assign active_sel_o = r_active_sel;

`ifdef PROJECT_SWITCH_LOCK_EN
    logic r_lock;
    assign w_lock_set = w_wr_cycle & wbs_sel_i[2] & wbs_dat_i[16];
    assign w_lock     = r_lock;

    // Sticky lock: only a bus reset clears it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_lock <= 1'b0;
        end else if (w_lock_set) begin
            r_lock <= 1'b1;
        end
    end
`else
    assign w_lock_set = 1'b0;
    assign w_lock     = 1'b0;
`endif

    // Single-cycle ack, forced low for a cycle between back-to-back accesses.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_acc & ~r_ack;
        end
    end

    // Next-state logic and switch-start decision.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_tgt = w_wdat;
        case (r_state)
            S_IDLE: begin
                if (w_sel_ok) begin
                    // A live write supersedes any pending request.
                    if (w_wdat != r_active_sel) begin
                        w_start     = 1'b1;
                        w_start_tgt = w_wdat;
                    end
                end else if (r_pending && !w_lock_set && (r_pend_target != r_active_sel)) begin
                    w_start     = 1'b1;
                    w_start_tgt = r_pend_target;
                end
                if (w_start) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!wbs_cyc_i || (r_cnt == c_DRAIN_LAST)) begin
                    w_state_nxt = S_ISOLATE;
                end
            end
            S_ISOLATE: begin
                if (r_cnt == c_GUARD_LAST) begin
                    w_state_nxt = S_RESET;
                end
            end
            S_RESET: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and per-state cycle counter (cleared on every transition).
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Target capture; the visible select changes only when RESET is entered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_target     <= '0;
            r_active_sel <= '0;
        end else begin
            if (w_start) begin
                r_target <= w_start_tgt;
            end
            if ((r_state == S_ISOLATE) && (w_state_nxt == S_RESET)) begin
                r_active_sel <= r_target;
            end
        end
    end

    // Pending request and error flag bookkeeping.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_pending     <= 1'b0;
            r_pend_target <= '0;
            r_err         <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_pending <= 1'b0;
            end else if (w_sel_ok) begin
                r_pending     <= 1'b1;
                r_pend_target <= w_wdat;
            end
            if (w_lock_set) begin
                r_pending <= 1'b0;
            end
            if (w_sel_bad) begin
                r_err <= 1'b1;
            end else if (w_sel_ok) begin
                r_err <= 1'b0;
            end
        end
    end

    // State-decoded outputs: isolation spans ISOLATE through RELEASE.
    always_comb begin
        switch_busy_o = (r_state != S_IDLE);
        io_isolate_o  = 1'b0;
        switch_irq_o  = 1'b0;
        proj_rst_o    = ~(c_ONE << r_active_sel);
        case (r_state)
            S_ISOLATE, S_RESET: begin
                io_isolate_o = 1'b1;
                proj_rst_o   = '1;
            end
            S_RELEASE: begin
                io_isolate_o = 1'b1;
                switch_irq_o = 1'b1;
                proj_rst_o   = ~(c_ONE << r_target);
            end
            default: begin
            end
        endcase
    end

    // Config readback image.
    always_comb begin
        cfg_dat_o                 = '0;
        cfg_dat_o[SEL_BITS-1:0]   = r_active_sel;
        cfg_dat_o[8]              = switch_busy_o;
        cfg_dat_o[9]              = r_pending;
        cfg_dat_o[10]             = r_err;
        cfg_dat_o[16]             = w_lock;
    end

endmodule
`default_nettype wire
